fifo_pkt_reader: RTL and testbench

//   Drains the synchronous FIFO and presents its data as a valid/ready stream framed

---
 rtl/fifo_pkt_reader.sv | 86 ++++++++
 tb/tb_fifo_pkt_reader.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_pkt_reader.sv
// FIFO read-side adapter: drains a registered-output FIFO into a valid/ready
// stream framed into PKT_LEN-beat packets, using a 3-entry skid buffer.
module fifo_pkt_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int PKT_LEN    = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [CNT_WIDTH-1:0]  pkt_count,
    output logic                  busy
);

    logic [DATA_WIDTH-1:0] mem [3];
    logic [1:0]            occ;
    logic [1:0]            head;
    logic [1:0]            tail;
    logic                  rd_pend;
    logic [15:0]           beat;
    logic                  push;
    logic                  pop;
    logic                  at_last;
    logic [2:0]            credit_used;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Credits count both buffered beats and the read still in flight,
    // so the buffer can never overflow regardless of m_ready.
    assign credit_used = {1'b0, occ} + {2'b00, rd_pend};
    assign fifo_rd_en  = en & ~fifo_empty & ~rst & (credit_used < 3'd3);

    assign push    = rd_pend;
    assign m_valid = (occ != 2'd0);
    assign pop     = m_valid & m_ready;
    assign at_last = (beat == 16'(PKT_LEN - 1));
    assign m_last  = m_valid & at_last;
    assign m_data  = m_valid ? mem[head] : '0;
    assign busy    = rd_pend | m_valid;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= fifo_dout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ       <= 2'd0;
            head      <= 2'd0;
            tail      <= 2'd0;
            rd_pend   <= 1'b0;
            beat      <= 16'd0;
            pkt_count <= '0;
        end else begin
            rd_pend <= fifo_rd_en & ~fifo_empty;
            if (push) begin
                tail <= ptr_inc(tail);
            end
            if (pop) begin
                head <= ptr_inc(head);
                if (at_last) begin
                    beat      <= 16'd0;
                    pkt_count <= pkt_count + CNT_WIDTH'(1);
                end else begin
                    beat <= beat + 16'd1;
                end
            end
            unique case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Randomised and directed bench for fifo_pkt_reader against a queue-level
// model of the buffer, the in-flight read and packet framing.
module tb_fifo_pkt_reader;

    localparam int PKT_LEN = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        fifo_empty = 1'b1;
    logic [7:0]  fifo_dout = 8'h00;
    logic        fifo_rd_en;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [7:0]  m_data;
    logic        m_last;
    logic [15:0] pkt_count;
    logic        busy;

    fifo_pkt_reader #(
        .DATA_WIDTH(8),
        .PKT_LEN   (PKT_LEN),
        .CNT_WIDTH (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .fifo_empty(fifo_empty),
        .fifo_dout (fifo_dout),
        .fifo_rd_en(fifo_rd_en),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .pkt_count (pkt_count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rd_total = 0;
    bit armed = 0;

    // Source FIFO contents and the reference model state
    logic [7:0]  src[$];
    logic [7:0]  mbuf[$];
    bit          mpend = 0;
    logic [7:0]  mpdata = 8'h00;
    int          mbeats = 0;
    logic [15:0] mpkts = 16'd0;

    // Actual transfers observed on the stream
    logic [7:0] log_d[$];
    bit         log_l[$];
    int         log_t[$];

    bit rd_c, xf_c, rst_c;

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic check_outputs();
        bit         ev, el, eb, erd;
        logic [7:0] ed;
        ev  = (mbuf.size() != 0);
        ed  = ev ? mbuf[0] : 8'h00;
        el  = ev && ((mbeats % PKT_LEN) == PKT_LEN - 1);
        eb  = mpend || ev;
        erd = en && (src.size() != 0) && !rst && ((mbuf.size() + int'(mpend)) < 3);
        checks++;
        if (fifo_rd_en !== erd || m_valid !== ev || m_data !== ed ||
            m_last !== el || busy !== eb || pkt_count !== mpkts) begin
            errors++;
            if (errors < 20)
                $display("FAIL cycle%0d rd_en %b/%b valid %b/%b data %h/%h last %b/%b busy %b/%b pkts %0d/%0d (got/exp)",
                         cyc, fifo_rd_en, erd, m_valid, ev, m_data, ed,
                         m_last, el, busy, eb, pkt_count, mpkts);
        end
    endtask

    task automatic model_edge();
        bit had_src;
        had_src = (src.size() != 0);
        if (rst_c) begin
            mbuf.delete();
            mpend  = 0;
            mbeats = 0;
            mpkts  = 16'd0;
        end else begin
            if (xf_c) begin
                if ((mbeats % PKT_LEN) == PKT_LEN - 1) mpkts = mpkts + 16'd1;
                mbeats++;
                void'(mbuf.pop_front());
            end
            if (mpend) mbuf.push_back(mpdata);
            mpend = rd_c && had_src;
        end
        if (rd_c && had_src) begin
            mpdata    = src.pop_front();
            fifo_dout = mpdata;
        end
    endtask

    // One clock: settle inputs, check at the falling edge, advance at the rising edge
    task automatic cycle();
        fifo_empty = (src.size() == 0);
        @(negedge clk);
        if (armed) check_outputs();
        rd_c  = fifo_rd_en;
        xf_c  = m_ready && (mbuf.size() != 0);
        rst_c = rst;
        if (fifo_rd_en) rd_total++;
        if (m_valid && m_ready) begin
            log_d.push_back(m_data);
            log_l.push_back(m_last);
            log_t.push_back(cyc);
        end
        @(posedge clk);
        #1;
        model_edge();
        if (rst_c) armed = 1;
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic clear_logs();
        log_d.delete();
        log_l.delete();
        log_t.delete();
        rd_total = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run(3);
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic check_log(input string nm, input logic [7:0] first, input int n);
        int bad_d, bad_l;
        logic [7:0] e;
        bad_d = 0;
        bad_l = 0;
        chk({nm, "_beats"}, log_d.size(), n);
        for (int i = 0; i < n && i < log_d.size(); i++) begin
            e = first + 8'(i);
            if (log_d[i] !== e) bad_d++;
            if (log_l[i] != ((i % PKT_LEN) == PKT_LEN - 1)) bad_l++;
        end
        chk({nm, "_data_bad"}, bad_d, 0);
        chk({nm, "_last_bad"}, bad_l, 0);
    endtask

    logic [7:0] sent[$];

    initial begin
        int fed, bad_d, bad_l, w;
        logic [7:0] v;

        // Reset with a non-empty FIFO, then stream 8 bytes
        for (int i = 0; i < 8; i++) src.push_back(8'h10 + 8'(i));
        rst = 1'b1;
        run(3);
        chk("reset_rd_en_count", rd_total, 0);
        chk("reset_valid", int'(m_valid), 0);
        chk("reset_pkt_count", int'(pkt_count), 0);
        chk("reset_busy", int'(busy), 0);
        rst = 1'b0;
        clear_logs();
        run(14);
        check_log("stream", 8'h10, 8);
        if (log_t.size() == 8) chk("stream_consecutive", log_t[7] - log_t[0], 7);
        else chk("stream_consecutive_n", log_t.size(), 8);
        chk("stream_pkt_count", int'(pkt_count), 2);

        // Backpressure: credits must cap reads at three
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) src.push_back(8'h10 + 8'(i));
        run(10);
        chk("bp_rd_count", rd_total, 3);
        chk("bp_valid", int'(m_valid), 1);
        chk("bp_head", int'(m_data), 'h10);
        chk("bp_no_xfer", log_d.size(), 0);
        m_ready = 1'b1;
        run(15);
        check_log("bp_drain", 8'h10, 6);

        // Random fill, random ready and occasional en gaps
        do_reset();
        sent.delete();
        fed = 0;
        for (int c = 0; c < 20000 && log_d.size() < 1000; c++) begin
            if (fed < 1000 && $urandom_range(0, 9) < 6) begin
                v = 8'($urandom);
                src.push_back(v);
                sent.push_back(v);
                fed++;
            end
            m_ready = 1'($urandom_range(0, 1));
            en      = ($urandom_range(0, 9) != 0);
            cycle();
        end
        chk("rand_beats", log_d.size(), 1000);
        bad_d = 0;
        bad_l = 0;
        for (int i = 0; i < log_d.size() && i < sent.size(); i++) begin
            if (log_d[i] !== sent[i]) bad_d++;
            if (log_l[i] != ((i % PKT_LEN) == PKT_LEN - 1)) bad_l++;
        end
        chk("rand_data_bad", bad_d, 0);
        chk("rand_last_bad", bad_l, 0);
        chk("rand_pkt_count", int'(pkt_count), 250);

        // Enable gating after two beats of a packet
        en = 1'b1;
        m_ready = 1'b1;
        do_reset();
        src.push_back(8'h20);
        src.push_back(8'h21);
        w = 0;
        while (log_d.size() < 2 && w < 20) begin
            cycle();
            w++;
        end
        chk("gate_first_two", log_d.size(), 2);
        en = 1'b0;
        for (int i = 2; i < 6; i++) src.push_back(8'h20 + 8'(i));
        rd_total = 0;
        run(10);
        chk("gate_no_reads", rd_total, 0);
        chk("gate_held", log_d.size(), 2);
        chk("gate_no_last", int'(log_l[0] | log_l[1]), 0);
        en = 1'b1;
        run(15);
        check_log("gate_resume", 8'h20, 6);

        // Reset while two beats are buffered and a read is in flight
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) src.push_back(8'h30 + 8'(i));
        w = 0;
        while (!(mbuf.size() == 2 && mpend) && w < 10) begin
            cycle();
            w++;
        end
        chk("midrst_reached", int'(mbuf.size() == 2 && mpend), 1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("midrst_valid", int'(m_valid), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_pkt_count", int'(pkt_count), 0);
        clear_logs();
        m_ready = 1'b1;
        run(15);
        check_log("midrst_after", 8'h33, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
